// File: rtl/wb_trace_fifo.sv
// Writeback commit trace FIFO: captures register commits until frozen or full, then drains them one per Pop.
// Optional dropped-commit counter port Ovf_Count is enabled by defining WB_TRACE_OVF_COUNT_EN.
module wb_trace_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PTR_W = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              WB_Valid,
    input  logic [4:0]        WB_RegDest,
    input  logic [31:0]       WB_Data,
    input  logic [31:0]       WB_PC,
    input  logic              Freeze,
    input  logic              Pop,
    output logic [31:0]       Head_PC,
    output logic [31:0]       Head_Data,
    output logic [4:0]        Head_RegDest,
    output logic              Empty,
    output logic              Full,
    output logic [PTR_W:0]    Count,
    output logic              Draining,
`ifdef WB_TRACE_OVF_COUNT_EN
    output logic              Overflow,
    output logic [15:0]       Ovf_Count
`else
    output logic              Overflow
`endif
);

    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        CAPTURE = 1'b0,
        DRAIN   = 1'b1
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic [4:0]  rd;
    } entry_t;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_d;
    entry_t           mem_q [DEPTH];
    entry_t           wr_entry, next_entry;
    logic             commit, push, pop, drop;

    // Qualify commits and compute next occupancy and state.
    always_comb begin
        commit     = WB_Valid && (WB_RegDest != 5'd0);
        push       = (state_q == CAPTURE) && commit && !Full;
        pop        = (state_q == DRAIN) && Pop && !Empty;
        drop       = (state_q == DRAIN) && commit;
        wr_entry   = '{pc: WB_PC, data: WB_Data, rd: WB_RegDest};
        next_entry = mem_q[PTR_W'(rd_ptr_q + 1'b1)];

        count_d = Count;
        if (push) begin
            count_d = Count + 1'b1;
        end else if (pop) begin
            count_d = Count - 1'b1;
        end

        state_d = state_q;
        case (state_q)
            CAPTURE: if (Freeze || (count_d == CNT_W'(DEPTH))) state_d = DRAIN;
            DRAIN:   if (!Freeze && (count_d == '0))            state_d = CAPTURE;
            default: state_d = CAPTURE;
        endcase
    end

    // Entry storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge Clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // Control FSM, pointers, flags and first-word-fall-through head register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= CAPTURE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            Count        <= '0;
            Empty        <= 1'b1;
            Full         <= 1'b0;
            Draining     <= 1'b0;
            Overflow     <= 1'b0;
            Head_PC      <= '0;
            Head_Data    <= '0;
            Head_RegDest <= '0;
        end else begin
            state_q  <= state_d;
            Draining <= (state_d == DRAIN);
            Count    <= count_d;
            Empty    <= (count_d == '0);
            Full     <= (count_d == CNT_W'(DEPTH));
            if (drop) begin
                Overflow <= 1'b1;
            end
            if (push) begin
                wr_ptr_q <= PTR_W'(wr_ptr_q + 1'b1);
            end
            if (pop) begin
                rd_ptr_q <= PTR_W'(rd_ptr_q + 1'b1);
            end
            // Push and pop are mutually exclusive: pushes only in CAPTURE, pops only in DRAIN.
            if (push && Empty) begin
                Head_PC      <= wr_entry.pc;
                Head_Data    <= wr_entry.data;
                Head_RegDest <= wr_entry.rd;
            end else if (pop) begin
                if (Count == CNT_W'(1)) begin
                    Head_PC      <= '0;
                    Head_Data    <= '0;
                    Head_RegDest <= '0;
                end else begin
                    Head_PC      <= next_entry.pc;
                    Head_Data    <= next_entry.data;
                    Head_RegDest <= next_entry.rd;
                end
            end
        end
    end

`ifdef WB_TRACE_OVF_COUNT_EN
    // Saturating count of commits dropped while draining.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Ovf_Count <= '0;
        end else if (drop && (Ovf_Count != 16'hFFFF)) begin
            Ovf_Count <= Ovf_Count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/wb_trace_fifo.md
WB_TRACE_FIFO -- requirements
Module: wb_trace_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning the number of trace entries (power of two, 4..64).
REQ-002 The block SHALL have parameter PTR_W, default 4, meaning log2(DEPTH).
REQ-003 The block SHALL have port Clock  in  1  meaning the pipeline clock (ClkOut domain); this is the only clock.
REQ-004 The block SHALL have port Reset  in  1  meaning reset, synchronous and active-high.
REQ-005 The block SHALL have port WB_Valid  in  1  meaning writeback commit strobe (MEMWB RegWrite).
REQ-006 The block SHALL have port WB_RegDest  in  5  meaning destination register of the commit.
REQ-007 The block SHALL have port WB_Data  in  32  meaning value written back (WB mux output).
REQ-008 The block SHALL have port WB_PC  in  32  meaning PC of the committing instruction.
REQ-009 The block SHALL have port Freeze  in  1  meaning a level request to stop capture and enter drain.
REQ-010 The block SHALL have port Pop  in  1  meaning a one-cycle step pulse that advances the head.
REQ-011 The block SHALL have port Head_PC  out  32  meaning PC of the oldest entry.
REQ-012 The block SHALL have port Head_Data  out  32  meaning data of the oldest entry.
REQ-013 The block SHALL have port Head_RegDest  out  5  meaning register of the oldest entry.
REQ-014 The block SHALL have port Empty  out  1 and port Full  out  1, meaning FIFO status flags.
REQ-015 The block SHALL have port Count  out  PTR_W+1  meaning the number of stored entries.
REQ-016 The block SHALL have port Draining  out  1  meaning the FSM is in DRAIN.
REQ-017 The block SHALL have port Overflow  out  1  meaning sticky flag: a commit was dropped.

Function
REQ-018 The FSM SHALL have exactly two states, CAPTURE and DRAIN; Draining SHALL be 1 only in DRAIN.
REQ-019 In CAPTURE, a push SHALL occur on a cycle with WB_Valid=1 and WB_RegDest!=0 and Full=0; commits to $0 SHALL never be stored.
REQ-020 In CAPTURE, Pop SHALL be ignored.
REQ-021 CAPTURE SHALL go to DRAIN on the edge where Freeze=1, or on the edge where Full becomes 1 (including the push that fills the FIFO).
REQ-022 In DRAIN, pushes SHALL be blocked; any qualifying commit (REQ-019 condition minus Full) SHALL set Overflow.
REQ-023 In DRAIN, Pop with Empty=0 SHALL remove the head; Pop with Empty=1 SHALL be ignored.
REQ-024 DRAIN SHALL return to CAPTURE on the first edge where Empty=1 and Freeze=0, including the edge of the pop that empties the FIFO while Freeze=0.
REQ-025 Head_* outputs SHALL be registered and first-word-fall-through: an entry pushed into an empty FIFO at edge N SHALL appear on Head_* after edge N.
REQ-026 A pop at edge N SHALL present the next entry on Head_* after edge N.
REQ-027 Head_* outputs SHALL be 0 whenever Empty=1.
REQ-028 Read and write pointers SHALL be PTR_W bits and wrap from DEPTH-1 to 0.
REQ-029 Count SHALL equal writes minus reads, in the range 0..DEPTH.
REQ-030 Full SHALL equal (Count==DEPTH), and Empty SHALL equal (Count==0).
REQ-031 Overflow SHALL be cleared only by Reset.

Reset
REQ-032 While Reset=1 at an edge, the FSM SHALL go to CAPTURE; pointers, Count, Overflow and Head_* SHALL become 0; Empty SHALL become 1, and Full and Draining SHALL become 0.
REQ-033 Reset SHALL take priority over push, pop and Freeze on the same edge; stored entries SHALL be discarded.

Configuration
REQ-034 With WB_TRACE_OVF_COUNT_EN defined, the block SHALL have extra port Ovf_Count  out  16, which increments once per dropped commit, saturates at 16'hFFFF and resets to 0.
REQ-035 Without WB_TRACE_OVF_COUNT_EN, the block SHALL have neither that port nor that counter, and all other behaviour SHALL be identical.

Verification
REQ-036 Reset, then 3 commits (R8=0x11 at PC 0x10, R9=0x22 at PC 0x14, R10=0x33 at PC 0x18), Freeze=1, 3 Pops -> Head sequence (0x10,R8,0x11), (0x14,R9,0x22), (0x18,R10,0x33); then Empty=1 and Head_*=0.
REQ-037 16 consecutive commits with Freeze=0 -> Full=1 and Draining=1 after the 16th; a 17th commit -> Overflow=1, Count=16, Ovf_Count=1 (with macro).
REQ-038 Commit to R0 with WB_Data=0xDEAD -> Count remains 0 and Empty remains 1.
REQ-039 Fill to 16, pop 16 times with Freeze=0 -> after the 16th pop Empty=1 and Draining=0; the next commit is stored with Count=1 (pointer wrap check).
REQ-040 Pop pulses in CAPTURE with Count=2 -> Count stays 2; Reset asserted mid-DRAIN with Count=5 -> all outputs at reset values on the next cycle.
